// File: rtl/cpu_core_mc.sv
// Multi-cycle core: 16-bit instructions, 16 x DATA_W register file, handshaked instruction
// and data ports, sequenced FETCH -> DECODE -> EXEC -> (MEM) -> WB, with a sticky HALT.
module cpu_core_mc #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned PC_W    = 6,
    parameter int unsigned DADDR_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [15:0]        imem_rdata,
    input  logic               imem_ready,
    output logic               dmem_rd,
    output logic               dmem_wr,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ready,
    output logic               halted
);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpSub  = 4'h1;
    localparam logic [3:0] OpAnd  = 4'h2;
    localparam logic [3:0] OpOr   = 4'h3;
    localparam logic [3:0] OpXor  = 4'h4;
    localparam logic [3:0] OpAddi = 4'h5;
    localparam logic [3:0] OpLw   = 4'h6;
    localparam logic [3:0] OpSw   = 4'h7;
    localparam logic [3:0] OpCmp  = 4'h8;
    localparam logic [3:0] OpLi   = 4'h9;
    localparam logic [3:0] OpMov  = 4'hA;
    localparam logic [3:0] OpJ    = 4'hB;
    localparam logic [3:0] OpJal  = 4'hC;
    localparam logic [3:0] OpJr   = 4'hD;
    localparam logic [3:0] OpBeq  = 4'hE;
    localparam logic [3:0] OpHalt = 4'hF;

    localparam logic [PC_W-1:0]   PcOne  = PC_W'(1);
    // CMP "greater" pattern: lower half of the word set; "less" is its complement.
    localparam logic [DATA_W-1:0] LoOnes = {DATA_W{1'b1}} >> (DATA_W / 2);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [PC_W-1:0]     npc_q, npc_d;
    logic [DATA_W-1:0]   rf_q [16];
    logic [DATA_W-1:0]   rf_d [16];

    logic [3:0]          op, rs_idx, rt_idx, rd_idx;
    logic [DATA_W-1:0]   imm4_ext, imm8_ext, link_val;
    logic [PC_W-1:0]     jaddr, pc_inc;
    logic [DATA_W-1:0]   alu_res;
    logic [PC_W-1:0]     next_pc;
    logic                is_mem_op;
    logic                wb_has;
    logic [3:0]          wb_idx;
    logic                rf_we;

    assign op        = ir_q[15:12];
    assign rs_idx    = ir_q[11:8];
    assign rt_idx    = ir_q[7:4];
    assign rd_idx    = ir_q[3:0];
    assign imm4_ext  = {{(DATA_W - 4){ir_q[3]}}, ir_q[3:0]};
    assign imm8_ext  = {{(DATA_W - 8){ir_q[7]}}, ir_q[7:0]};
    assign jaddr     = ir_q[PC_W-1:0];
    assign pc_inc    = pc_q + PcOne;
    assign link_val  = {{(DATA_W - PC_W){1'b0}}, pc_inc};
    assign is_mem_op = (op == OpLw) || (op == OpSw);

    always_comb begin
        alu_res = '0;
        unique case (op)
            OpAdd:               alu_res = a_q + b_q;
            OpSub:               alu_res = a_q - b_q;
            OpAnd:               alu_res = a_q & b_q;
            OpOr:                alu_res = a_q | b_q;
            OpXor:               alu_res = a_q ^ b_q;
            OpAddi, OpLw, OpSw:  alu_res = a_q + imm4_ext;
            OpCmp: begin
                if (a_q == b_q) begin
                    alu_res = '1;
                end else if (a_q > b_q) begin
                    alu_res = LoOnes;
                end else begin
                    alu_res = ~LoOnes;
                end
            end
            OpLi:                alu_res = imm8_ext;
            OpMov:               alu_res = a_q;
            OpJal:               alu_res = link_val;
            default:             alu_res = '0;
        endcase
    end

    always_comb begin
        next_pc = pc_inc;
        unique case (op)
            OpJ, OpJal: next_pc = jaddr;
            OpJr:       next_pc = a_q[PC_W-1:0];
            OpBeq: begin
                if (a_q == b_q) begin
                    next_pc = pc_inc + imm4_ext[PC_W-1:0];
                end
            end
            default:    next_pc = pc_inc;
        endcase
    end

    // Destination register selection; R0 as a destination means no write at all.
    always_comb begin
        wb_has = 1'b0;
        wb_idx = '0;
        unique case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpXor, OpCmp, OpMov: begin
                wb_has = 1'b1;
                wb_idx = rd_idx;
            end
            OpAddi, OpLw: begin
                wb_has = 1'b1;
                wb_idx = rt_idx;
            end
            OpLi: begin
                wb_has = 1'b1;
                wb_idx = rs_idx;
            end
            OpJal: begin
                wb_has = 1'b1;
                wb_idx = 4'hF;
            end
            default: begin
                wb_has = 1'b0;
                wb_idx = '0;
            end
        endcase
    end

    assign rf_we = (state_q == StWb) && wb_has && (wb_idx != 4'h0);

    always_comb begin
        rf_d = rf_q;
        if (rf_we) begin
            rf_d[wb_idx] = res_q;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        npc_d   = npc_q;
        unique case (state_q)
            StFetch: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d     = rf_q[rs_idx];
                b_d     = rf_q[rt_idx];
                state_d = (op == OpHalt) ? StHalt : StExec;
            end
            StExec: begin
                res_d   = alu_res;
                npc_d   = next_pc;
                state_d = is_mem_op ? StMem : StWb;
            end
            StMem: begin
                if (dmem_ready) begin
                    if (op == OpLw) begin
                        res_d = dmem_rdata;
                    end
                    state_d = StWb;
                end
            end
            StWb: begin
                pc_d    = npc_q;
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            npc_q   <= '0;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            npc_q   <= npc_d;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Strobes are gated by rst so an access in flight is dropped the moment reset rises.
    assign imem_req   = (state_q == StFetch) && !rst;
    assign imem_addr  = pc_q;
    assign dmem_rd    = (state_q == StMem) && (op == OpLw) && !rst;
    assign dmem_wr    = (state_q == StMem) && (op == OpSw) && !rst;
    assign dmem_addr  = res_q[DADDR_W-1:0];
    assign dmem_wdata = b_q;
    assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_cpu_core_mc.sv
// Bench for cpu_core_mc: ISA-level reference model feeds fetch/data-access scoreboards; a
// monitor process pops and compares on every completed handshake.
module tb_cpu_core_mc;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned PC_W    = 6;
    localparam int unsigned DADDR_W = 6;

    logic               clk;
    logic               rst;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [15:0]        imem_rdata;
    logic               imem_ready;
    logic               dmem_rd;
    logic               dmem_wr;
    logic [DADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic [DATA_W-1:0]  dmem_rdata;
    logic               dmem_ready;
    logic               halted;

    cpu_core_mc #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .DADDR_W(DADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .dmem_rd   (dmem_rd),
        .dmem_wr   (dmem_wr),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready),
        .halted    (halted)
    );

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [15:0] data;
    } mem_op_t;

    logic [15:0] imem [64];
    logic [15:0] dmem [64];
    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    int      exp_pc[$];
    mem_op_t exp_mem[$];
    int      fetch_cyc[$];

    logic [15:0] m_r [16];
    logic [15:0] m_mem [64];
    logic [5:0]  m_pc;
    bit          m_halted;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int ifix = 0, dfix = 0, dly_max = 0;
    int idly = 0, ddly = 0, icnt = 0, dcnt = 0, drun = 0;
    bit chk_len = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic void set_reg(input logic [3:0] i, input logic [15:0] v);
        if (i != 4'h0) m_r[i] = v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_pc = '0;
        m_halted = 0;
    endtask

    // Instruction-set reference: executes up to n instructions from the current model state.
    task automatic model_step(input int n);
        for (int k = 0; k < n; k++) begin
            logic [15:0] ins, a, b, i4, ea;
            logic [5:0]  npc;
            mem_op_t     mo;
            if (m_halted) break;
            ins = imem[m_pc];
            exp_pc.push_back(int'(m_pc));
            a   = m_r[ins[11:8]];
            b   = m_r[ins[7:4]];
            i4  = {{12{ins[3]}}, ins[3:0]};
            ea  = a + i4;
            npc = m_pc + 6'd1;
            case (ins[15:12])
                4'h0: set_reg(ins[3:0], a + b);
                4'h1: set_reg(ins[3:0], a - b);
                4'h2: set_reg(ins[3:0], a & b);
                4'h3: set_reg(ins[3:0], a | b);
                4'h4: set_reg(ins[3:0], a ^ b);
                4'h5: set_reg(ins[7:4], ea);
                4'h6: begin
                    mo.wr = 0; mo.addr = ea[5:0]; mo.data = '0;
                    exp_mem.push_back(mo);
                    set_reg(ins[7:4], m_mem[ea[5:0]]);
                end
                4'h7: begin
                    mo.wr = 1; mo.addr = ea[5:0]; mo.data = b;
                    exp_mem.push_back(mo);
                    m_mem[ea[5:0]] = b;
                end
                4'h8: set_reg(ins[3:0], (a == b) ? 16'hFFFF : (a > b) ? 16'h00FF : 16'hFF00);
                4'h9: set_reg(ins[11:8], {{8{ins[7]}}, ins[7:0]});
                4'hA: set_reg(ins[3:0], a);
                4'hB: npc = ins[5:0];
                4'hC: begin
                    set_reg(4'hF, {10'd0, npc});
                    npc = ins[5:0];
                end
                4'hD: npc = a[5:0];
                4'hE: if (a == b) npc = m_pc + 6'd1 + i4[5:0];
                default: m_halted = 1;
            endcase
            if (!m_halted) m_pc = npc;
        end
    endtask

    // Memory responders: ready after a per-access delay; fetches only while expectations remain.
    always begin
        @(posedge clk);
        #1;
        if (imem_req && exp_pc.size() > 0) begin
            if (icnt == 0) idly = (ifix >= 0) ? ifix : int'($urandom_range(0, dly_max));
            imem_ready = (icnt >= idly);
            icnt++;
        end else begin
            imem_ready = 1'b0;
            icnt = 0;
        end
        if (dmem_rd || dmem_wr) begin
            if (dcnt == 0) ddly = (dfix >= 0) ? dfix : int'($urandom_range(0, dly_max));
            dmem_ready = (dcnt >= ddly);
            dcnt++;
        end else begin
            dmem_ready = 1'b0;
            dcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req && imem_ready && exp_pc.size() > 0) begin
                chk("fetch_pc", int'(imem_addr), exp_pc.pop_front());
                fetch_cyc.push_back(cyc);
            end
            if (dmem_rd || dmem_wr) begin
                drun++;
                chk("strobe_excl", int'(dmem_rd & dmem_wr), 0);
                if (dmem_ready) begin
                    if (exp_mem.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_access: got addr 0x%0h expected none", dmem_addr);
                    end else begin
                        mem_op_t mo;
                        mo = exp_mem.pop_front();
                        chk("mem_kind", int'(dmem_wr), int'(mo.wr));
                        chk("mem_addr", int'(dmem_addr), int'(mo.addr));
                        if (mo.wr) begin
                            chk("mem_wdata", int'(dmem_wdata), int'(mo.data));
                            dmem[dmem_addr] = dmem_wdata;
                        end
                    end
                    if (chk_len) chk("strobe_len", drun, dfix + 1);
                    drun = 0;
                end
            end else begin
                drun = 0;
            end
        end else begin
            drun = 0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_pc.delete();
        exp_mem.delete();
        fetch_cyc.delete();
        chk("rst_imem_req", int'(imem_req), 0);
        chk("rst_strobes", int'({dmem_rd, dmem_wr}), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_pc", int'(imem_addr), 0);
        chk("rst_dmem_bus", int'({dmem_addr, dmem_wdata}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_imem_req", int'(imem_req), 1);
        chk("rel_pc", int'(imem_addr), 0);
        model_reset();
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while ((exp_pc.size() != 0 || exp_mem.size() != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_leftover"}, exp_pc.size() + exp_mem.size(), 0);
        exp_pc.delete();
        exp_mem.delete();
        repeat (6) @(negedge clk);
        chk({nm, "_halted"}, int'(halted), int'(m_halted));
    endtask

    task automatic clear_mem(input bit rnd);
        for (int i = 0; i < 64; i++) begin
            imem[i] = 16'hF000;
            dmem[i] = rnd ? 16'($urandom) : 16'h0000;
            m_mem[i] = dmem[i];
        end
    endtask

    initial begin
        rst = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        clear_mem(0);
        model_reset();

        // Add chain with fixed zero-wait memories, latency and halt behaviour.
        ifix = 0; dfix = 0; chk_len = 1;
        do_reset();
        imem[0] = 16'h9105; imem[1] = 16'h92FD; imem[2] = 16'h0123;
        imem[3] = 16'h7030; imem[4] = 16'hF000;
        model_step(10);
        drain("add");
        if (fetch_cyc.size() >= 5) begin
            chk("lat_three_instr", fetch_cyc[3] - fetch_cyc[0], 12);
            chk("lat_store", fetch_cyc[4] - fetch_cyc[3], 5);
        end else begin
            chk("lat_fetch_count", fetch_cyc.size(), 5);
        end
        begin
            int bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!halted || imem_req || dmem_rd || dmem_wr) bad++;
            end
            chk("halt_frozen", bad, 0);
        end

        // Store/load with three wait cycles on the data port.
        dfix = 3;
        do_reset();
        clear_mem(0);
        imem[0] = 16'h917F; imem[1] = 16'h7012; imem[2] = 16'h6042;
        imem[3] = 16'h7045; imem[4] = 16'hF000;
        model_step(10);
        drain("swlw");
        dfix = 0;

        // CMP equal / less / greater.
        do_reset();
        clear_mem(0);
        imem[0] = 16'h9105; imem[1] = 16'h9205; imem[2] = 16'h8123; imem[3] = 16'h9209;
        imem[4] = 16'h8124; imem[5] = 16'h9202; imem[6] = 16'h8125; imem[7] = 16'h7030;
        imem[8] = 16'h7041; imem[9] = 16'h7052; imem[10] = 16'hF000;
        model_step(20);
        drain("cmp");

        // JAL at the top of the PC range, then JR through the wrapped link.
        do_reset();
        clear_mem(0);
        imem[0] = 16'hB03F; imem[63] = 16'hC03F;
        model_step(3);
        drain("jal");
        imem[63] = 16'hDF00; imem[0] = 16'h70F1; imem[1] = 16'hF000;
        model_step(10);
        drain("jr");

        // R0 writes discarded; BEQ with imm4=-1 spins in place.
        do_reset();
        clear_mem(0);
        imem[0] = 16'h9009; imem[1] = 16'hA005; imem[2] = 16'h9601;
        imem[3] = 16'h9701; imem[4] = 16'hE67F;
        model_step(8);
        drain("beq");
        imem[4] = 16'h7050; imem[5] = 16'hF000;
        model_step(5);
        drain("r0");

        // Reset while a load waits in MEM.
        dfix = 10; chk_len = 0;
        do_reset();
        clear_mem(0);
        dmem[3] = 16'h1234; m_mem[3] = 16'h1234;
        imem[0] = 16'h9155; imem[1] = 16'h6013;
        model_step(2);
        begin
            int t = 0;
            while (!dmem_rd && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("mem_pending", int'(dmem_rd), 1);
        end
        do_reset();
        dfix = 0;
        imem[0] = 16'h7010; imem[1] = 16'hF000;
        model_step(4);
        drain("rst_mem");

        // Random programs with random handshake delays, followed by a register dump.
        ifix = -1; dfix = -1; dly_max = 2;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            clear_mem(1);
            for (int i = 0; i < 64; i++) begin
                imem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
            end
            model_step(120);
            drain("rand");
            for (int k = 1; k < 16; k++) begin
                logic [3:0] kk;
                kk = 4'(k);
                imem[6'(int'(m_pc) + k - 1)] = {4'h7, 4'h0, kk, kk};
            end
            imem[6'(int'(m_pc) + 15)] = 16'hF000;
            model_step(20);
            drain("dump");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_core_mc.md
CPU_CORE_MC -- requirements
Module: cpu_core_mc

Interface
REQ-001 Parameter DATA_W, default 16, datapath and register width (≥16).
REQ-002 Parameter PC_W, default 6, program counter and instruction-address width (≤12).
REQ-003 Parameter DADDR_W, default 6, data-memory address width (≤DATA_W).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 imem_req  out  1  instruction fetch request.
REQ-007 imem_addr  out  PC_W  fetch address, equal to the PC.
REQ-008 imem_rdata  in  16  instruction word.
REQ-009 imem_ready  in  1  fetch completes in any cycle where imem_req and imem_ready are both high.
REQ-010 dmem_rd / dmem_wr  out  1 each  data read/write strobes, never both high.
REQ-011 dmem_addr  out  DADDR_W  low bits of the effective address.
REQ-012 dmem_wdata  out  DATA_W  store data.
REQ-013 dmem_rdata  in  DATA_W  load data.
REQ-014 dmem_ready  in  1  data access completes in any cycle where a strobe and dmem_ready are both high.
REQ-015 halted  out  1  core is stopped in HALT.

Function
REQ-016 Instruction fields: op=[15:12], Rs=[11:8], Rt=[7:4], Rd=[3:0]; imm4=[3:0] and imm8=[7:0] are sign-extended to DATA_W; jaddr=[11:0] is truncated to PC_W.
REQ-017 Register file: 16 x DATA_W; R0 always reads 0 and writes to R0 are discarded.
REQ-018 Opcodes:
- 0 ADD / 1 SUB / 2 AND / 3 OR / 4 XOR: Rd <= Rs op Rt.
- 5 ADDI: Rt <= Rs + imm4.
- 6 LW: Rt <= mem[Rs + imm4].
- 7 SW: mem[Rs + imm4] <= Rt.
- 8 CMP: Rd <= all-ones if Rs==Rt; low half ones if Rs>Rt unsigned; high half ones if Rs<Rt.
- 9 LI: Rs <= imm8.
- A MOV: Rd <= Rs.
- B J: pc <= jaddr.
- C JAL: R15 <= zero-extended pc+1, then pc <= jaddr.
- D JR: pc <= Rs[PC_W-1:0].
- E BEQ: if Rs==Rt, pc <= pc+1+imm4.
- F HALT.
REQ-019 Arithmetic wraps modulo 2^DATA_W; no flags are exported.
REQ-020 All PC arithmetic wraps modulo 2^PC_W.
REQ-021 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-022 FETCH: imem_req=1 and imem_addr=pc; on imem_ready, latch the instruction into IR and go to DECODE; otherwise stay in FETCH.
REQ-023 DECODE: read Rs/Rt into operand registers; go to EXEC, or to HALT if op=F.
REQ-024 EXEC: compute the ALU result, effective address and next PC, registered; go to MEM for LW/SW, else to WB.
REQ-025 MEM: hold dmem_rd or dmem_wr, address and data stable until dmem_ready; on ready, latch load data and go to WB.
REQ-026 WB: perform the single register write (if any) and the pc update (pc+1 unless jump/taken branch); go to FETCH.
REQ-027 Latency with ready tied high: 4 cycles per instruction, 5 for LW/SW.
REQ-028 When JAL writes R15, R15 takes pc+1; no other write occurs.
REQ-029 HALT: halted=1, all strobes 0, state frozen until rst.
REQ-030 Strobes are low in every state other than FETCH (imem_req) and MEM (dmem_*).

Reset
REQ-031 rst asserted: immediately set state=FETCH, pc=0, IR=0, all registers=0, halted=0, and all outputs 0 except imem_req, which is 1 from the first cycle after release.
REQ-032 rst mid-MEM or mid-FETCH: drop the strobe immediately, discard the access, and commit no register write.

Verification
REQ-033 LI R1,5; LI R2,-3; ADD R3,R1,R2, ready=1 -> R3=2, retired in 12 cycles.
REQ-034 LI R1,0x7F; SW R1,[R0+2]; LW R4,[R0+2], with dmem_ready delayed 3 cycles -> dmem_wdata=0x007F at address 2, R4=0x007F, strobes held 4 cycles each.
REQ-035 CMP with R1=5, R2=5 / 9 / 2 -> Rd = FFFF / FF00 / 00FF (DATA_W=16).
REQ-036 JAL 0x3F at pc=0x3F (PC_W=6) -> R15=0x00 (wrapped), pc=0x3F; then JR R15 -> pc=0.
REQ-037 BEQ taken with imm4=-1 at pc=4 -> pc=4; LI R0,9 then MOV R5,R0 -> R5=0.
REQ-038 HALT -> halted=1 with no strobes for 20 cycles; rst pulse -> pc=0 and fetch resumes; rst during MEM -> no write and no register change.
